// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// The line-level constants name the framing bits so the FSM reads as the frame format.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Cycle counter width: clog2(clks), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned clks);
      return (clks <= 1) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle.
// clear restarts the period so a frame's first bit is full length.
module bit_timer
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned          CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // With CLKS_PER_BIT=1 the counter sits at 0 and tick is permanently high.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Words are accepted through a valid/ready handshake only while the line is idle.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy
);

   localparam int unsigned         BIT_W    = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
      $error("serial_frame_tx: DATA_W must be 1..16");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks
      $error("serial_frame_tx: CLKS_PER_BIT must be >= 1");
   end

   state_t              state;
   logic                ready_en;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   shreg_next;
   logic [BIT_W-1:0]    bit_cnt;
   logic                parity_bit;
   logic                tick;
   logic                transfer;

   // Keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   assign in_ready   = (state == IDLE) && ready_en;
   assign transfer   = in_valid && in_ready;
   assign shreg_next = shreg >> 1;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (transfer),
      .tick  (tick)
   );

   // tx is loaded with the next bit on the edge that enters each state, so tx and busy stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= LINE_IDLE;
         busy       <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx   <= LINE_IDLE;
               busy <= 1'b0;
               if (transfer) begin
                  shreg      <= in_data;
                  parity_bit <= ^in_data;
                  state      <= START;
                  tx         <= START_BIT;
                  busy       <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        tx    <= parity_bit;
                     end else begin
                        state <= STOP;
                        tx    <= STOP_BIT;
                     end
                  end else begin
                     shreg   <= shreg_next;
                     tx      <= shreg_next[0];
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  tx    <= STOP_BIT;
               end
            end
            STOP: begin
               if (tick) begin
                  state <= IDLE;
                  tx    <= LINE_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= LINE_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
